// File: rtl/sync_align.sv
`default_nettype none
// ============================================================================
//  Module   : sync_align
//  Purpose  : Delays de/hsync/vsync by LATENCY ce-qualified cycles to match a
//             pixel datapath, and tags each outgoing pixel with its column
//             (x_out) and row (y_out) index plus a start-of-frame flag.
//  Options  : define SYNC_ALIGN_FRAME_CNT_EN to add a 16-bit wrapping frame
//             counter output (frame_cnt) that counts delayed-vsync rises.
//  Revision : 1.0  initial release
// ============================================================================
module sync_align #(
  parameter int LATENCY = 3,   // pipeline depth in ce cycles, 1..16
  parameter int X_W     = 12,  // column index width
  parameter int Y_W     = 12   // row index width
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           de_in,
  input  logic           hsync_in,
  input  logic           vsync_in,
  output logic           de_out,
  output logic           hsync_out,
  output logic           vsync_out,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           sof_out
`ifdef SYNC_ALIGN_FRAME_CNT_EN
  ,
  output logic [15:0]    frame_cnt
`endif
);

  // Delay-line stages; the last stage drives the sync outputs directly.
  logic [LATENCY-1:0] de_q, de_d;
  logic [LATENCY-1:0] hs_q, hs_d;
  logic [LATENCY-1:0] vs_q, vs_d;

  // Chains include the live input at bit 0 so that bit LATENCY-1 is the
  // value about to enter the output stage (works for LATENCY=1 as well).
  logic [LATENCY:0] de_chain;
  logic [LATENCY:0] hs_chain;
  logic [LATENCY:0] vs_chain;

  // Pixel position counters and the registered tag outputs.
  logic [X_W-1:0] col_q, col_d;
  logic [Y_W-1:0] line_q, line_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           sof_q, sof_d;

  // Events seen at the output-stage boundary: the counters track the stream
  // as it leaves the delay line, one edge ahead of the output registers, so
  // x_out/y_out/sof_out land in the same cycle as the pixel on de_out.
  logic pre_de;
  logic cur_de;
  logic pre_vs;
  logic cur_vs;
  logic de_fall;
  logic vs_rise;

  assign de_chain = {de_q, de_in};
  assign hs_chain = {hs_q, hsync_in};
  assign vs_chain = {vs_q, vsync_in};

  assign pre_de  = de_chain[LATENCY-1];
  assign cur_de  = de_q[LATENCY-1];
  assign pre_vs  = vs_chain[LATENCY-1];
  assign cur_vs  = vs_q[LATENCY-1];
  assign de_fall = cur_de & ~pre_de;
  assign vs_rise = ~cur_vs & pre_vs;

  assign de_out    = de_q[LATENCY-1];
  assign hsync_out = hs_q[LATENCY-1];
  assign vsync_out = vs_q[LATENCY-1];
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign sof_out   = sof_q;

`ifdef SYNC_ALIGN_FRAME_CNT_EN
  logic [15:0] frame_q, frame_d;
  assign frame_cnt = frame_q;

  // Frame counter next state: wraps naturally at 16 bits.
  always_comb begin
    frame_d = frame_q;
    if (vs_rise) begin
      frame_d = frame_q + 16'd1;
    end
  end

  // Frame counter register, advancing only on ce cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (ce) begin
      frame_q <= frame_d;
    end
  end
`endif

  // Next-state for delay line, counters and tag outputs.
  always_comb begin
    de_d   = de_chain[LATENCY-1:0];
    hs_d   = hs_chain[LATENCY-1:0];
    vs_d   = vs_chain[LATENCY-1:0];
    col_d  = col_q;
    line_d = line_q;
    // Tags show the counters before this cycle's update.
    x_d    = col_q;
    y_d    = line_q;
    sof_d  = pre_de & (col_q == '0) & (line_q == '0);

    if (pre_de && (col_q != '1)) begin
      col_d = col_q + X_W'(1);
    end

    if (de_fall) begin
      col_d = '0;
      if (line_q != '1) begin
        line_d = line_q + Y_W'(1);
      end
    end

    // Applied last so a coincident vsync rise overrides the line increment.
    if (vs_rise) begin
      line_d = '0;
    end
  end

  // State registers: asynchronous clear, frozen whenever ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q   <= '0;
      hs_q   <= '0;
      vs_q   <= '0;
      col_q  <= '0;
      line_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      sof_q  <= 1'b0;
    end else if (ce) begin
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      col_q  <= col_d;
      line_q <= line_d;
      x_q    <= x_d;
      y_q    <= y_d;
      sof_q  <= sof_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_align.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_align
//  Purpose  : Self-checking bench for sync_align. Two instances run from the
//             same stimulus: A (LATENCY=3, 12-bit coords) and B (LATENCY=1,
//             2-bit coords, exercising saturation).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_align;

  logic clk    = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n  = 1'b1;
  logic ce     = 1'b0;
  logic de_in  = 1'b0;
  logic hs_in  = 1'b0;
  logic vs_in  = 1'b0;

  logic        a_de, a_hs, a_vs, a_sof;
  logic [11:0] a_x, a_y;
  logic        b_de, b_hs, b_vs, b_sof;
  logic [1:0]  b_x, b_y;
`ifdef SYNC_ALIGN_FRAME_CNT_EN
  logic [15:0] a_frm, b_frm;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit rec_en   = 1'b0;

  int qax[$], qay[$], qas[$];
  int qbx[$], qby[$], qbs[$];

  sync_align #(.LATENCY(3), .X_W(12), .Y_W(12)) u_a (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .de_in(de_in), .hsync_in(hs_in), .vsync_in(vs_in),
    .de_out(a_de), .hsync_out(a_hs), .vsync_out(a_vs),
    .x_out(a_x), .y_out(a_y), .sof_out(a_sof)
`ifdef SYNC_ALIGN_FRAME_CNT_EN
    , .frame_cnt(a_frm)
`endif
  );

  sync_align #(.LATENCY(1), .X_W(2), .Y_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .de_in(de_in), .hsync_in(hs_in), .vsync_in(vs_in),
    .de_out(b_de), .hsync_out(b_hs), .vsync_out(b_vs),
    .x_out(b_x), .y_out(b_y), .sof_out(b_sof)
`ifdef SYNC_ALIGN_FRAME_CNT_EN
    , .frame_cnt(b_frm)
`endif
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Every ce edge records the input triple {de,hs,vs}; an instance with
  // latency L shows the triple recorded L ce-edges earlier. Position tags
  // follow directly from the rules applied to that delayed stream.
  int          L[2]  = '{3, 1};
  int          XM[2] = '{4095, 3};
  int          YM[2] = '{4095, 3};
  logic [2:0]  hist[0:4095];
  int          n;
  int          col[2], line[2], ex[2], ey[2], frm[2], ef[2];
  logic [2:0]  prev[2], e_exp[2];
  logic        es[2];

  initial begin : model_p
    logic [2:0] e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0;
        for (int i = 0; i < 2; i++) begin
          col[i] = 0; line[i] = 0; ex[i] = 0; ey[i] = 0;
          frm[i] = 0; ef[i] = 0; prev[i] = 3'b0; e_exp[i] = 3'b0; es[i] = 1'b0;
        end
      end else if (ce) begin
        if (n < 4096) hist[n] = {de_in, hs_in, vs_in};
        n++;
        for (int i = 0; i < 2; i++) begin
          e = (n >= L[i]) ? hist[n - L[i]] : 3'b0;
          e_exp[i] = e;
          ex[i] = col[i];
          ey[i] = line[i];
          es[i] = e[2] && (col[i] == 0) && (line[i] == 0);
          if (e[2]) col[i] = (col[i] < XM[i]) ? col[i] + 1 : XM[i];
          if (prev[i][2] && !e[2]) begin
            col[i]  = 0;
            line[i] = (line[i] < YM[i]) ? line[i] + 1 : YM[i];
          end
          if (!prev[i][0] && e[0]) begin
            line[i] = 0;
            frm[i]  = (frm[i] + 1) % 65536;
          end
          ef[i]   = frm[i];
          prev[i] = e;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("a_de",  a_de,  e_exp[0][2]);
        chk("a_hs",  a_hs,  e_exp[0][1]);
        chk("a_vs",  a_vs,  e_exp[0][0]);
        chk("a_sof", a_sof, es[0]);
        if (e_exp[0][2]) begin
          chk("a_x", a_x, ex[0]);
          chk("a_y", a_y, ey[0]);
        end
        chk("b_de",  b_de,  e_exp[1][2]);
        chk("b_hs",  b_hs,  e_exp[1][1]);
        chk("b_vs",  b_vs,  e_exp[1][0]);
        chk("b_sof", b_sof, es[1]);
        if (e_exp[1][2]) begin
          chk("b_x", b_x, ex[1]);
          chk("b_y", b_y, ey[1]);
        end
`ifdef SYNC_ALIGN_FRAME_CNT_EN
        chk("a_frame", a_frm, ef[0]);
        chk("b_frame", b_frm, ef[1]);
`endif
        if (rec_en) begin
          if (a_de) begin qax.push_back(a_x); qay.push_back(a_y); qas.push_back(a_sof); end
          if (b_de) begin qbx.push_back(b_x); qby.push_back(b_y); qbs.push_back(b_sof); end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic d, input logic h, input logic v, input logic c);
    de_in = d; hs_in = h; vs_in = v; ce = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic vsync_pulse();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
  endtask

  task automatic line_of(input int k);
    repeat (k) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(1);
  endtask

  task automatic clear_rec();
    qax.delete(); qay.delete(); qas.delete();
    qbx.delete(); qby.delete(); qbs.delete();
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  int exp_x[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_y[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int exp_s[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
  int exp_bx[6] = '{0, 1, 2, 3, 3, 3};

  initial begin
    #1 rst_n = 1'b0;
    #22;
    chk("rst_a_de", a_de, 0);
    chk("rst_a_x",  a_x,  0);
    chk("rst_a_sof", a_sof, 0);
    chk("rst_b_vs", b_vs, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single de pulse through the pipeline: out after third capturing edge.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("lat_a_e1", a_de, 0);
    chk("lat_b_e1", b_de, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lat_a_e2", a_de, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lat_a_e3", a_de, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lat_a_e4", a_de, 0);
    idle(2);

    // Pulse with ce alternating: needs three ce=1 edges, frozen on ce=0.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ce_a_before", a_de, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ce_a_arrive", a_de, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ce_a_frozen", a_de, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ce_a_leave", a_de, 0);
    idle(3);

    // Frame: vsync then two 4-pixel lines.
    clear_rec();
    rec_en = 1'b1;
    vsync_pulse();
    line_of(4);
    line_of(4);
    idle(4);
    rec_en = 1'b0;
    chk("frame_count", qax.size(), 8);
    if (qax.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("frame_x%0d", i), qax[i], exp_x[i]);
        chk($sformatf("frame_y%0d", i), qay[i], exp_y[i]);
        chk($sformatf("frame_sof%0d", i), qas[i], exp_s[i]);
      end
    end

    // Narrow X: a 6-pixel line saturates at 3.
    clear_rec();
    rec_en = 1'b1;
    vsync_pulse();
    line_of(6);
    idle(2);
    rec_en = 1'b0;
    chk("xsat_count", qbx.size(), 6);
    if (qbx.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("xsat_x%0d", i), qbx[i], exp_bx[i]);
    end

    // de fall coincident with vsync rise: next line must be row 0.
    vsync_pulse();
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    clear_rec();
    rec_en = 1'b1;
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    rec_en = 1'b0;
    chk("coinc_count", qay.size(), 2);
    if (qay.size() == 2) begin
      chk("coinc_y0", qay[0], 0);
      chk("coinc_y1", qay[1], 0);
      chk("coinc_sof", qas[0], 1);
    end

    // Narrow Y: five lines saturate the row index at 3.
    clear_rec();
    rec_en = 1'b1;
    vsync_pulse();
    repeat (5) line_of(2);
    idle(2);
    rec_en = 1'b0;
    chk("ysat_count", qby.size(), 10);
    if (qby.size() == 10) begin
      chk("ysat_y4", qby[4], 2);
      chk("ysat_y9", qby[9], 3);
    end

    // Line with ce gaps between pixels.
    vsync_pulse();
    repeat (4) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle(4);

    // Reset mid-line with the clock stopped.
    vsync_pulse();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    clk_en = 1'b0;
    de_in  = 1'b0;
    #20;
    rst_n = 1'b0;
    #1;
    chk("arst_a_de",  a_de,  0);
    chk("arst_a_x",   a_x,   0);
    chk("arst_a_vs",  a_vs,  0);
    chk("arst_b_de",  b_de,  0);
    chk("arst_b_x",   b_x,   0);
`ifdef SYNC_ALIGN_FRAME_CNT_EN
    chk("arst_a_frame", a_frm, 0);
`endif
    #10;
    rst_n = 1'b1;
    #3;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    line_of(3);
    vsync_pulse();
    vsync_pulse();
    vsync_pulse();
    idle(4);
`ifdef SYNC_ALIGN_FRAME_CNT_EN
    chk("frame_cnt_a", a_frm, 3);
    chk("frame_cnt_b", b_frm, 3);
`endif

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
